// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the control unit (master) and the data memory (slave).
interface data_memory_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  read_memory;
    logic                  write_memory;
    logic                  memory_to_register;
    logic [ADDR_WIDTH-1:0] address;
    logic [1:0]            size;
    logic                  load_unsigned;
    logic [DATA_WIDTH-1:0] writeData;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] readData;
    logic                  resp_valid;
    logic                  error;

    modport master (
        output req_valid, read_memory, write_memory, memory_to_register,
               address, size, load_unsigned, writeData, result,
        input  req_ready, readData, resp_valid, error
    );

    modport slave (
        input  req_valid, read_memory, write_memory, memory_to_register,
               address, size, load_unsigned, writeData, result,
        output req_ready, readData, resp_valid, error
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Data memory with handshake, wait states, sub-word access and registered write-back mux.
// Optional macro DMEM_PERF_CNT_EN adds saturating load/store/fault counters.
module data_memory_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst,
    data_memory_ctrl_if.slave  bus
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count,
    output logic [15:0]        err_count
`endif
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  rd_q, wr_q, m2r_q, uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic [DATA_WIDTH-1:0] wdata_q, result_q;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic                  accept, do_access, fault, mem_we;
    logic                  cur_rd, cur_wr, cur_m2r, cur_uns;
    logic [ADDR_WIDTH-1:0] cur_addr, widx_full;
    logic [1:0]            cur_size;
    logic [DATA_WIDTH-1:0] cur_wdata, cur_result;
    logic [LB-1:0]         offset;
    logic [IW-1:0]         widx;
    logic [BYTES-1:0]      be;
    logic [DATA_WIDTH-1:0] word, lshift, wshift, ldata;

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                     input logic [1:0] sz,
                                                     input logic uns);
        logic [DATA_WIDTH-1:0] out;
        logic                  sb;
        int                    nb;
        out = v;
        nb  = 8 << sz;
        if (nb < DATA_WIDTH) begin
            sb = v[nb-1] & ~uns;
            for (int i = 0; i < DATA_WIDTH; i++)
                if (i >= nb) out[i] = sb;
        end
        return out;
    endfunction

    assign accept = (state_q == S_IDLE) && bus.req_valid;

    // With zero wait states the access happens on the accept edge, so the live inputs are used.
    assign cur_rd     = (state_q == S_IDLE) ? bus.read_memory        : rd_q;
    assign cur_wr     = (state_q == S_IDLE) ? bus.write_memory       : wr_q;
    assign cur_m2r    = (state_q == S_IDLE) ? bus.memory_to_register : m2r_q;
    assign cur_uns    = (state_q == S_IDLE) ? bus.load_unsigned      : uns_q;
    assign cur_addr   = (state_q == S_IDLE) ? bus.address            : addr_q;
    assign cur_size   = (state_q == S_IDLE) ? bus.size               : size_q;
    assign cur_wdata  = (state_q == S_IDLE) ? bus.writeData          : wdata_q;
    assign cur_result = (state_q == S_IDLE) ? bus.result             : result_q;

    always_comb begin
        offset    = cur_addr[LB-1:0];
        widx_full = cur_addr >> LB;
        widx      = widx_full[IW-1:0];
        fault     = (cur_rd && cur_wr)
                 || ((cur_addr & ((ADDR_WIDTH'(1) << cur_size) - ADDR_WIDTH'(1))) != '0)
                 || (widx_full >= ADDR_WIDTH'(DEPTH))
                 || (int'(cur_size) > LB);
        for (int b = 0; b < BYTES; b++)
            be[b] = (b >= int'(offset)) && (b < int'(offset) + (1 << cur_size));
        word   = mem_q[widx];
        lshift = word >> {offset, 3'b000};
        wshift = cur_wdata << {offset, 3'b000};
        ldata  = extend(lshift, cur_size, cur_uns);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!bus.read_memory && !bus.write_memory) begin
                        rdata_d = bus.result;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else if (WAIT_STATES == 0) begin
                        do_access = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = WS_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (do_access) begin
            err_d   = fault;
            rdata_d = (!fault && cur_rd && cur_m2r) ? ldata : cur_result;
        end
    end

    assign mem_we = do_access && cur_wr && !fault && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q     <= bus.read_memory;
            wr_q     <= bus.write_memory;
            m2r_q    <= bus.memory_to_register;
            uns_q    <= bus.load_unsigned;
            addr_q   <= bus.address;
            size_q   <= bus.size;
            wdata_q  <= bus.writeData;
            result_q <= bus.result;
        end
    end

    // Memory contents survive reset; only byte lanes selected by be are written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++)
                if (be[b]) mem_q[widx][b*8 +: 8] <= wshift[b*8 +: 8];
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.error      = err_q;
    assign bus.readData   = rdata_q;

`ifdef DMEM_PERF_CNT_EN
    logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q  <= 16'd0;
            wr_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else if (state_q == S_RESP) begin
            rd_cnt_q  <= sat_inc(rd_cnt_q,  rd_q && !wr_q && !err_q);
            wr_cnt_q  <= sat_inc(wr_cnt_q,  wr_q && !rd_q && !err_q);
            err_cnt_q <= sat_inc(err_cnt_q, err_q);
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed, table-driven bench for data_memory_ctrl (DATA_WIDTH=32, DEPTH=32, WAIT_STATES=2).
module tb_data_memory_ctrl;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DEPTH = 32;
    localparam int WS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef DMEM_PERF_CNT_EN
    logic [15:0] rd_count, wr_count, err_count;
`endif

    data_memory_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .WAIT_STATES(WS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_PERF_CNT_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count),
        .err_count(err_count)
`endif
    );

    typedef struct {
        logic        rd, wr, m2r, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata, result, exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rd, input logic wr, input logic m2r, input logic uns,
                                input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] res, input logic [31:0] exp, input logic ee,
                                input int lat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.m2r = m2r; v.uns = uns; v.size = sz;
        v.addr = addr; v.wdata = wd; v.result = res; v.exp_data = exp;
        v.exp_err = ee; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v, output logic [31:0] data, output logic err,
                           output int lat, output bit busy_ok, output bit hold_ok);
        @(negedge clk);
        bus.read_memory        = v.rd;
        bus.write_memory       = v.wr;
        bus.memory_to_register = v.m2r;
        bus.load_unsigned      = v.uns;
        bus.size               = v.size;
        bus.address            = v.addr;
        bus.writeData          = v.wdata;
        bus.result             = v.result;
        bus.req_valid          = 1'b1;
        @(posedge clk);
        #1;
        // Scramble everything after accept: the block must work from the latched request.
        bus.req_valid          = 1'b0;
        bus.read_memory        = ~v.rd;
        bus.write_memory       = ~v.wr;
        bus.memory_to_register = ~v.m2r;
        bus.load_unsigned      = ~v.uns;
        bus.size               = ~v.size;
        bus.address            = v.addr ^ 32'h0000_0044;
        bus.writeData          = ~v.wdata;
        bus.result             = ~v.result;
        busy_ok = 1'b1;
        hold_ok = 1'b0;
        data    = '0;
        err     = 1'b0;
        lat     = 1;
        while (lat <= 40) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) break;
            if (bus.req_ready !== 1'b0 || bus.error !== 1'b0) busy_ok = 1'b0;
            lat++;
        end
        if (lat > 40) begin
            lat = -1;
        end else begin
            data = bus.readData;
            err  = bus.error;
            @(negedge clk);
            hold_ok = (bus.resp_valid === 1'b0) && (bus.error === 1'b0) &&
                      (bus.readData === data) && (bus.req_ready === 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          l;
        bit          q, h;

        //          rd wr m2r uns sz  addr        wdata         result        expected      err lat
        tbl.push_back(mk(0, 1, 0, 0, 2, 32'h10, 32'hDEADBEEF, 32'h0000AAAA, 32'h0000AAAA, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 2, 32'h10, 32'h0,        32'h00001111, 32'hDEADBEEF, 0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h11, 32'hFFFFFF7F, 32'h00002222, 32'h00002222, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 2, 32'h10, 32'h0,        32'h0,        32'hDEAD7FEF, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 0, 32'h13, 32'h0,        32'h0,        32'hFFFFFFDE, 0, 3));
        tbl.push_back(mk(1, 0, 1, 1, 0, 32'h13, 32'h0,        32'h0,        32'h000000DE, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 1, 32'h12, 32'h0,        32'h0,        32'hFFFFDEAD, 0, 3));
        tbl.push_back(mk(1, 0, 1, 1, 1, 32'h12, 32'h0,        32'h0,        32'h0000DEAD, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 1, 32'h11, 32'h0,        32'h00001234, 32'h00001234, 1, 3));
        tbl.push_back(mk(0, 1, 0, 0, 2, 32'h80, 32'hFFFFFFFF, 32'h00001234, 32'h00001234, 1, 3));
        tbl.push_back(mk(1, 1, 1, 0, 2, 32'h10, 32'h0,        32'h00001234, 32'h00001234, 1, 3));
        tbl.push_back(mk(1, 0, 1, 0, 2, 32'h00, 32'h0,        32'h00003333, 32'h00000000, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 2, 32'h10, 32'h0,        32'h0,        32'hDEAD7FEF, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 2, 32'h10, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 2, 32'h10, 32'h0,        32'h600DF00D, 32'h600DF00D, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 3, 32'h10, 32'h0,        32'h00004444, 32'h00004444, 1, 3));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h16, 32'hBEEF5678, 32'h00000005, 32'h00000005, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 2, 32'h14, 32'h0,        32'h0,        32'h56780000, 0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h14, 32'h00000080, 32'h00000006, 32'h00000006, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 0, 32'h14, 32'h0,        32'h0,        32'hFFFFFF80, 0, 3));
        tbl.push_back(mk(1, 0, 1, 1, 1, 32'h16, 32'h0,        32'h0,        32'h00005678, 0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 2, 32'h7C, 32'h13579BDF, 32'h00000007, 32'h00000007, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 2, 32'h7C, 32'h0,        32'h0,        32'h13579BDF, 0, 3));

        bus.req_valid = 1'b0; bus.read_memory = 1'b0; bus.write_memory = 1'b0;
        bus.memory_to_register = 1'b0; bus.load_unsigned = 1'b0; bus.size = 2'd0;
        bus.address = '0; bus.writeData = '0; bus.result = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("reset error", {31'b0, bus.error}, 32'd0);
        chk("reset readData", bus.readData, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_req(tbl[i], d, e, l, q, h);
            chk($sformatf("v%0d readData", i), d, tbl[i].exp_data);
            chk($sformatf("v%0d error", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
            chk($sformatf("v%0d latency", i), 32'(l), 32'(tbl[i].exp_lat));
            chk($sformatf("v%0d busy_quiet", i), {31'b0, q}, 32'd1);
            chk($sformatf("v%0d hold_after_resp", i), {31'b0, h}, 32'd1);
        end

        // Reset while a store waits: the store must be dropped and outputs cleared at once.
        @(negedge clk);
        bus.read_memory = 1'b0; bus.write_memory = 1'b1; bus.memory_to_register = 1'b0;
        bus.size = 2'd2; bus.address = 32'h20; bus.writeData = 32'h55; bus.result = 32'h99;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midwait req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("pre-reset readData", bus.readData, 32'h13579BDF);
        rst = 1'b1;
        #1;
        chk("async reset readData", bus.readData, 32'd0);
        chk("async reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("async reset error", {31'b0, bus.error}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-reset req_ready", {31'b0, bus.req_ready}, 32'd1);
        run_req(mk(1, 0, 1, 0, 2, 32'h20, 32'h0, 32'hABCD, 32'h0, 0, 3), d, e, l, q, h);
        chk("aborted store readData", d, 32'h0);
        chk("aborted store error", {31'b0, e}, 32'd0);
        chk("aborted store latency", 32'(l), 32'd3);

`ifdef DMEM_PERF_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_req(mk(1, 0, 1, 0, 2, 32'h10, 32'h0, 32'h0, 32'hDEAD7FEF, 0, 3), d, e, l, q, h);
        run_req(mk(1, 0, 1, 0, 2, 32'h14, 32'h0, 32'h0, 32'h56780080, 0, 3), d, e, l, q, h);
        run_req(mk(1, 0, 0, 1, 1, 32'h16, 32'h0, 32'h1, 32'h1, 0, 3), d, e, l, q, h);
        run_req(mk(0, 1, 0, 0, 2, 32'h00, 32'h1, 32'h2, 32'h2, 0, 3), d, e, l, q, h);
        run_req(mk(0, 1, 0, 0, 0, 32'h01, 32'h2, 32'h3, 32'h3, 0, 3), d, e, l, q, h);
        run_req(mk(1, 0, 1, 0, 1, 32'h11, 32'h0, 32'h1234, 32'h1234, 1, 3), d, e, l, q, h);
        run_req(mk(0, 0, 0, 0, 2, 32'h00, 32'h0, 32'h7, 32'h7, 0, 1), d, e, l, q, h);
        chk("perf rd_count", {16'b0, rd_count}, 32'd3);
        chk("perf wr_count", {16'b0, wr_count}, 32'd2);
        chk("perf err_count", {16'b0, err_count}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("perf rd_count reset", {16'b0, rd_count}, 32'd0);
        chk("perf wr_count reset", {16'b0, wr_count}, 32'd0);
        chk("perf err_count reset", {16'b0, err_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
